merge_arbiter: RTL and testbench

MERGE_ARBITER -- requirements
Module: merge_arbiter

---
 rtl/merge_arbiter.sv | 126 ++++++++++++
 tb/tb_merge_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge_arbiter.sv
// Two-way merge of sorted FIFO streams into one output FIFO; once one side is
// exhausted the other side is passed through unchanged.
module merge_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_a_item,
  input  logic                  i_a_empty,
  input  logic                  i_a_done,
  output logic                  o_a_read,
  input  logic [DATA_WIDTH-1:0] i_b_item,
  input  logic                  i_b_empty,
  input  logic                  i_b_done,
  output logic                  o_b_read,
  input  logic                  i_out_afull,
  output logic [DATA_WIDTH-1:0] o_item,
  output logic                  o_write,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_count
);

  typedef enum logic [2:0] {
    StIdle,
    StMerge,
    StDrainA,
    StDrainB,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] item_q, item_d;
  logic                  write_q, write_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic a_exh, b_exh;
  logic a_rd, b_rd, pop, clr_cnt;

  assign a_exh = i_a_done & i_a_empty;
  assign b_exh = i_b_done & i_b_empty;

  always_comb begin
    state_d = state_q;
    a_rd    = 1'b0;
    b_rd    = 1'b0;
    clr_cnt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StMerge;
          clr_cnt = 1'b1;
        end
      end
      StMerge: begin
        // Exhaustion is checked first so no pop happens on the exit cycle.
        if (a_exh && b_exh) begin
          state_d = StDone;
        end else if (a_exh) begin
          state_d = StDrainB;
        end else if (b_exh) begin
          state_d = StDrainA;
        end else if (!i_a_empty && !i_b_empty && !i_out_afull) begin
          if (i_a_item <= i_b_item) a_rd = 1'b1;
          else                      b_rd = 1'b1;
        end
      end
      StDrainA: begin
        if (a_exh)                          state_d = StDone;
        else if (!i_a_empty && !i_out_afull) a_rd   = 1'b1;
      end
      StDrainB: begin
        if (b_exh)                          state_d = StDone;
        else if (!i_b_empty && !i_out_afull) b_rd   = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (!i_rst_n) begin
      a_rd = 1'b0;
      b_rd = 1'b0;
    end
  end

  assign pop = a_rd | b_rd;

  always_comb begin
    item_d  = item_q;
    write_d = pop;
    count_d = count_q;
    if (pop) begin
      item_d  = a_rd ? i_a_item : i_b_item;
      count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    if (clr_cnt) count_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      item_q  <= '0;
      write_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      write_q <= write_d;
      count_q <= count_d;
    end
  end

  assign o_a_read = a_rd;
  assign o_b_read = b_rd;
  assign o_item   = item_q;
  assign o_write  = write_q;
  assign o_count  = count_q;
  assign o_busy   = (state_q != StIdle);
  assign o_done   = (state_q == StDone);

endmodule

// File: tb/tb_merge_arbiter.sv
// Directed bench for merge_arbiter: FIFO models feed the DUT and a one-cycle
// write model checks every output cycle.
module tb_merge_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a_item, b_item, o_item;
  logic        a_empty, a_done, b_empty, b_done, afull;
  logic        o_a_read, o_b_read, o_write, o_busy, o_done;
  logic [15:0] o_count;

  merge_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_a_item   (a_item),
    .i_a_empty  (a_empty),
    .i_a_done   (a_done),
    .o_a_read   (o_a_read),
    .i_b_item   (b_item),
    .i_b_empty  (b_empty),
    .i_b_done   (b_done),
    .o_b_read   (o_b_read),
    .i_out_afull(afull),
    .o_item     (o_item),
    .o_write    (o_write),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [31:0] qa[$], qb[$], out_q[$];
  int          src_q[$];
  logic        pend_w = 1'b0;
  logic [31:0] pend_item = '0, last_item = '0;
  int          done_cnt = 0, rd_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    a_empty = (qa.size() == 0);
    b_empty = (qb.size() == 0);
    a_item  = a_empty ? 32'd0 : qa[0];
    b_item  = b_empty ? 32'd0 : qb[0];
  endtask

  // One clock cycle: check outputs at the falling edge, then pop the FIFO models.
  task automatic tick();
    logic ra, rb, rst_edge;
    @(negedge clk);
    ra = o_a_read;
    rb = o_b_read;
    check("write_lat", o_write, pend_w);
    if (pend_w) check("item_lat", o_item, pend_item);
    else        check("item_hold", o_item, last_item);
    if (o_write) begin
      check("write_after_done", done_cnt, 0);
      out_q.push_back(o_item);
      last_item = o_item;
    end
    check("one_read", ra & rb, 1'b0);
    check("a_read_empty", ra & a_empty, 1'b0);
    check("b_read_empty", rb & b_empty, 1'b0);
    if (!rst_n) check("read_in_reset", ra | rb, 1'b0);
    if (o_done) done_cnt++;
    if (ra | rb) rd_cnt++;
    if (ra) src_q.push_back(0);
    if (rb) src_q.push_back(1);
    pend_w    = (ra | rb) & rst_n;
    pend_item = ra ? a_item : b_item;
    rst_edge  = !rst_n;
    @(posedge clk);
    #1;
    if (rst_edge) begin
      pend_w    = 1'b0;
      last_item = '0;
    end
    if (ra && qa.size() > 0) void'(qa.pop_front());
    if (rb && qb.size() > 0) void'(qb.pop_front());
    drive();
  endtask

  task automatic load(input logic [31:0] a [8], input int na, input logic [31:0] b [8],
                      input int nb, input logic ad, input logic bd);
    qa.delete();
    qb.delete();
    out_q.delete();
    src_q.delete();
    for (int i = 0; i < na; i++) qa.push_back(a[i]);
    for (int i = 0; i < nb; i++) qb.push_back(b[i]);
    a_done   = ad;
    b_done   = bd;
    done_cnt = 0;
    rd_cnt   = 0;
    drive();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
    tick();
    tick();
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_idle_busy"}, o_busy, 1'b0);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] e [8], input int n,
                           input logic [15:0] cnt);
    check({tag, "_len"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++)
      check($sformatf("%s_item%0d", tag, i), out_q[i], e[i]);
    check({tag, "_count"}, o_count, cnt);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    afull = 1'b0;
    load('{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_write", o_write, 1'b0);
    check("rst_item", o_item, 32'd0);
    check("rst_count", o_count, 16'd0);
    check("rst_done", o_done, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic merge of two sorted streams.
    load('{1, 4, 9, 0, 0, 0, 0, 0}, 3, '{2, 3, 10, 0, 0, 0, 0, 0}, 3, 1'b1, 1'b1);
    pulse_start();
    check("merge_busy", o_busy, 1'b1);
    run_until_done("merge", 40);
    check_seq("merge", '{1, 2, 3, 4, 9, 10, 0, 0}, 6, 16'd6);

    // Tie goes to A.
    load('{5, 0, 0, 0, 0, 0, 0, 0}, 1, '{5, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1, 1'b1);
    pulse_start();
    run_until_done("tie", 40);
    check_seq("tie", '{5, 5, 0, 0, 0, 0, 0, 0}, 2, 16'd2);
    check("tie_src_len", src_q.size(), 2);
    if (src_q.size() == 2) begin
      check("tie_first_a", src_q[0], 0);
      check("tie_second_b", src_q[1], 1);
    end

    // One side empty but not exhausted: stall.
    load('{7, 0, 0, 0, 0, 0, 0, 0}, 1, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 1'b0);
    pulse_start();
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    check("stall_reads", rd_cnt, 0);
    check("stall_busy", o_busy, 1'b1);
    qb.push_back(32'd3);
    b_done = 1'b1;
    a_done = 1'b1;
    drive();
    run_until_done("stall", 40);
    check_seq("stall", '{3, 7, 0, 0, 0, 0, 0, 0}, 2, 16'd2);

    // Output almost-full mid-run; a stray start is ignored.
    load('{1, 3, 5, 7, 0, 0, 0, 0}, 4, '{2, 4, 6, 8, 0, 0, 0, 0}, 4, 1'b1, 1'b1);
    pulse_start();
    tick();
    tick();
    afull  = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) tick();
    check("afull_reads", rd_cnt, 0);
    check("afull_len", out_q.size(), 2);
    afull = 1'b0;
    pulse_start();
    run_until_done("afull", 60);
    check_seq("afull", '{1, 2, 3, 4, 5, 6, 7, 8}, 8, 16'd8);

    // A exhausted at start: B passes through unsorted.
    load('{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{8, 6, 0, 0, 0, 0, 0, 0}, 2, 1'b1, 1'b1);
    pulse_start();
    run_until_done("drainb", 40);
    check_seq("drainb", '{8, 6, 0, 0, 0, 0, 0, 0}, 2, 16'd2);

    // Reset mid-run, then a fresh run.
    load('{1, 2, 3, 4, 0, 0, 0, 0}, 4, '{5, 6, 7, 8, 0, 0, 0, 0}, 4, 1'b1, 1'b1);
    pulse_start();
    n = 0;
    while (out_q.size() < 2 && n < 40) begin
      tick();
      n++;
    end
    check("rstmid_reached", out_q.size() >= 2, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rstmid_write", o_write, 1'b0);
    check("rstmid_item", o_item, 32'd0);
    check("rstmid_count", o_count, 16'd0);
    check("rstmid_done", o_done, 1'b0);
    check("rstmid_busy", o_busy, 1'b0);
    rst_n = 1'b1;
    load('{1, 0, 0, 0, 0, 0, 0, 0}, 1, '{2, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1, 1'b1);
    tick();
    check("rstmid_idle_write", o_write, 1'b0);
    pulse_start();
    run_until_done("fresh", 40);
    check_seq("fresh", '{1, 2, 0, 0, 0, 0, 0, 0}, 2, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
